ldst_bus_sequencer: RTL and testbench
=====================================

# ldst_bus_sequencer

Sequences one load/store request at a time from the execution stage onto the data-memory bus. Runs a request/busy handshake, waits for the load response, and aligns the returned data before handing it to writeback. Misaligned requests are rejected with an alignment exception, and requests cancelled by a pipeline flush are aborted or drained. Sits between the execution-stage load/store unit and the data-memory port.

## Interface
Parameters: none.

Clock and reset: one clock (`iCLOCK`); reset `inRESET` is synchronous and active-low.

- `iCLOCK` in 1 — clock; all state changes on the rising edge.
- `inRESET` in 1 — synchronous active-low reset.
- `iEXE_VALID` in 1 — execution stage presents a request.
- `oEXE_BUSY` out 1 — sequencer cannot accept a request; high whenever state ≠ IDLE.
- `iEXE_RW` in 1 — 0 = load, 1 = store.
- `iEXE_ADDR` in 32 — byte address.
- `iEXE_DATA` in 32 — store data.
- `iEXE_ORDER` in 2 — access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- `iEXE_LOAD_SHIFT` in 2 — load alignment shift, in bytes.
- `iFLUSH` in 1 — pipeline flush; cancels any in-flight request.
- `oDATAIO_REQ` out 1 — bus request.
- `iDATAIO_BUSY` in 1 — bus cannot accept the request this cycle.
- `oDATAIO_RW`, `oDATAIO_ADDR[31:0]`, `oDATAIO_DATA[31:0]`, `oDATAIO_ORDER[1:0]` out — latched request fields.
- `oDATAIO_MASK` out 4 — byte enables.
- `iDATAIO_VALID` in 1 — load response strobe.
- `iDATAIO_DATA` in 32 — load response data.
- `oWB_VALID` out 1 — one-cycle completion pulse.
- `oWB_RW` out 1 — completed access type.
- `oWB_DATA` out 32 — aligned load data; 0 for stores.
- `oEXCEPT_ALIGN` out 1 — one-cycle misalignment pulse.
- `oEXCEPT_ADDR` out 32 — faulting address.

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- **Accept**: occurs in IDLE when `iEXE_VALID`=1 and `iFLUSH`=0. All request fields are latched.
- **Byte mask**:
  - order 0 → `4'b0001 << addr[1:0]`.
  - order 1 → `0011` if addr[1:0]=0, `1100` if addr[1:0]=2.
  - order 2 → `1111`.
- **Misaligned or illegal**: order 1 with addr[0]=1, order 2 with addr[1:0]≠0, or order 3.
  - Pulse `oEXCEPT_ALIGN` with `oEXCEPT_ADDR` = the address.
  - Stay in IDLE; no bus request, no writeback.
- **Aligned accept**: go to REQ. `oDATAIO_REQ`=1 is held in REQ with stable fields.
- **Bus accept**: the edge where `oDATAIO_REQ`=1 and `iDATAIO_BUSY`=0.
  - Store: `oWB_VALID` pulses with `oWB_RW`=1 and `oWB_DATA`=0; go to IDLE.
  - Load: go to WAIT.
- **WAIT**: on `iDATAIO_VALID`, compute `oWB_DATA = (iDATAIO_DATA >> 8*shift) & sizemask`.
  - sizemask: 0xFF for byte, 0xFFFF for half, 0xFFFFFFFF for word (zero-extended).
  - Pulse `oWB_VALID` with `oWB_RW`=0; go to IDLE.
- **Flush**:
  - In IDLE: blocks accept.
  - In REQ: drop `oDATAIO_REQ` next cycle and go to IDLE, even if BUSY=0 that same cycle; flush wins and there is no writeback.
  - In WAIT with `iDATAIO_VALID`=0: go to DRAIN.
  - In WAIT with `iDATAIO_VALID`=1: the response is discarded; go to IDLE.
  - In DRAIN: no effect.
- **DRAIN**: on `iDATAIO_VALID`, discard the response and go to IDLE. No writeback from DRAIN.
- **Spurious response**: `iDATAIO_VALID` in IDLE or REQ is ignored.
- **Reset**: any state → IDLE next edge, including mid-transaction. An outstanding response arriving after reset is ignored.

## Timing
- All outputs are registered except `oEXE_BUSY`, which is decoded from state.
- Reset values: every output is 0, including `oDATAIO_*`, `oWB_*` and `oEXCEPT_*`.
- Accept edge T → `oDATAIO_REQ`=1 in cycle T+1.
- Store with `iDATAIO_BUSY`=0 → bus accept at edge T+1 → `oWB_VALID` in cycle T+2. Next request can be accepted at edge T+2.
- Load: response edge R → `oWB_VALID` in cycle R+1.
- Alignment exception: accept edge T → `oEXCEPT_ALIGN` in cycle T+1. Back-to-back requests are accepted, since busy stays 0.
- `oWB_VALID` and `oEXCEPT_ALIGN` are one-cycle pulses and never high in the same cycle.

## Structure
- Shared package `ldst_seq_pkg`:
  - state encoding;
  - order constants `LDST_ORDER_BYTE`=0, `_HALF`=1, `_WORD`=2;
  - function `func_ldst_bytemask(order, addr)`;
  - function `func_ldst_misaligned(order, addr)`.
- Sub-module `ldst_load_align`: combinational shift by 8×shift, then size-mask to 32 bits. Used for the WAIT→writeback path.

## Test plan
- Store word to 0x100, data 0xDEADBEEF, BUSY held 2 cycles → REQ held 3 cycles with mask `1111`; `oWB_VALID`/`oWB_RW`=1 one cycle after the release edge.
- Load byte at 0x103, shift 0, response 0x11223344 → mask `1000`; `oWB_DATA`=0x00000044.
- Load half at 0x200, shift 2, response 0xAABBCCDD → mask `0011`; `oWB_DATA`=0x0000AABB.
- Load word at 0x102 → `oEXCEPT_ALIGN`=1, `oEXCEPT_ADDR`=0x102, `oDATAIO_REQ` never rises, `oEXE_BUSY` stays 0.
- Load word accepted, `iFLUSH` in WAIT, response 3 cycles later → DRAIN; no `oWB_VALID`; the next request is accepted the cycle after the response.
- `inRESET`=0 during REQ with BUSY=1 → all outputs 0 next cycle; a later `iDATAIO_VALID` produces no writeback.

Source files
------------

// File: rtl/ldst_seq_pkg.sv
// ldst_seq_pkg: shared state encoding, access-size constants and alignment helpers
package ldst_seq_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} ldst_state_t;
   localparam logic [1:0] LDST_ORDER_BYTE = 2'd0;
   localparam logic [1:0] LDST_ORDER_HALF = 2'd1;
   localparam logic [1:0] LDST_ORDER_WORD = 2'd2;
   function automatic logic [3:0] func_ldst_bytemask(input logic [1:0] order, input logic [1:0] addr);
      return order == LDST_ORDER_BYTE ? 4'b0001 << addr :
             order == LDST_ORDER_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
             order == LDST_ORDER_WORD ? 4'b1111 : 4'b0000;
   endfunction
   function automatic logic func_ldst_misaligned(input logic [1:0] order, input logic [1:0] addr);
      return (order == LDST_ORDER_HALF && addr[0]) || (order == LDST_ORDER_WORD && addr != 2'd0) || order == 2'd3;
   endfunction
endpackage

// File: rtl/ldst_load_align.sv
// ldst_load_align: shifts load response right by whole bytes, then zero-extends to the access size
module ldst_load_align
   import ldst_seq_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  shift,
   input  logic [1:0]  order,
   output logic [31:0] result
);
   logic [31:0] shifted;
   assign shifted = data >> {shift, 3'b000};
   assign result = order == LDST_ORDER_BYTE ? {24'd0, shifted[7:0]} :
                   order == LDST_ORDER_HALF ? {16'd0, shifted[15:0]} : shifted;
endmodule

// File: rtl/ldst_bus_sequencer.sv
// ldst_bus_sequencer: one-at-a-time load/store sequencer between execute stage and data-memory bus
module ldst_bus_sequencer
   import ldst_seq_pkg::*;
(
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iEXE_VALID,
   output logic        oEXE_BUSY,
   input  logic        iEXE_RW,
   input  logic [31:0] iEXE_ADDR,
   input  logic [31:0] iEXE_DATA,
   input  logic [1:0]  iEXE_ORDER,
   input  logic [1:0]  iEXE_LOAD_SHIFT,
   input  logic        iFLUSH,
   output logic        oDATAIO_REQ,
   input  logic        iDATAIO_BUSY,
   output logic        oDATAIO_RW,
   output logic [31:0] oDATAIO_ADDR,
   output logic [31:0] oDATAIO_DATA,
   output logic [1:0]  oDATAIO_ORDER,
   output logic [3:0]  oDATAIO_MASK,
   input  logic        iDATAIO_VALID,
   input  logic [31:0] iDATAIO_DATA,
   output logic        oWB_VALID,
   output logic        oWB_RW,
   output logic [31:0] oWB_DATA,
   output logic        oEXCEPT_ALIGN,
   output logic [31:0] oEXCEPT_ADDR
);
   ldst_state_t state;
   logic [1:0]  load_shift;
   logic [31:0] aligned;

   ldst_load_align u_align (
      .data   (iDATAIO_DATA),
      .shift  (load_shift),
      .order  (oDATAIO_ORDER),
      .result (aligned)
   );

   assign oEXE_BUSY = state != ST_IDLE;

   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         state         <= ST_IDLE;
         load_shift    <= 2'd0;
         oDATAIO_REQ   <= 1'b0;
         oDATAIO_RW    <= 1'b0;
         oDATAIO_ADDR  <= 32'd0;
         oDATAIO_DATA  <= 32'd0;
         oDATAIO_ORDER <= 2'd0;
         oDATAIO_MASK  <= 4'd0;
         oWB_VALID     <= 1'b0;
         oWB_RW        <= 1'b0;
         oWB_DATA      <= 32'd0;
         oEXCEPT_ALIGN <= 1'b0;
         oEXCEPT_ADDR  <= 32'd0;
      end else begin
         oWB_VALID     <= 1'b0;
         oEXCEPT_ALIGN <= 1'b0;
         case (state)
            ST_IDLE: if (iEXE_VALID && !iFLUSH) begin
               oDATAIO_RW    <= iEXE_RW;
               oDATAIO_ADDR  <= iEXE_ADDR;
               oDATAIO_DATA  <= iEXE_DATA;
               oDATAIO_ORDER <= iEXE_ORDER;
               oDATAIO_MASK  <= func_ldst_bytemask(iEXE_ORDER, iEXE_ADDR[1:0]);
               load_shift    <= iEXE_LOAD_SHIFT;
               if (func_ldst_misaligned(iEXE_ORDER, iEXE_ADDR[1:0])) begin
                  oEXCEPT_ALIGN <= 1'b1;
                  oEXCEPT_ADDR  <= iEXE_ADDR;
               end else begin
                  oDATAIO_REQ <= 1'b1;
                  state       <= ST_REQ;
               end
            end
            ST_REQ: if (iFLUSH) begin
               oDATAIO_REQ <= 1'b0;
               state       <= ST_IDLE;
            end else if (!iDATAIO_BUSY) begin
               oDATAIO_REQ <= 1'b0;
               if (oDATAIO_RW) begin
                  oWB_VALID <= 1'b1;
                  oWB_RW    <= 1'b1;
                  oWB_DATA  <= 32'd0;
                  state     <= ST_IDLE;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: if (iDATAIO_VALID) begin
               oWB_VALID <= !iFLUSH;
               oWB_RW    <= 1'b0;
               oWB_DATA  <= aligned;
               state     <= ST_IDLE;
            end else if (iFLUSH) begin
               state <= ST_DRAIN;
            end
            default: if (iDATAIO_VALID) state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ldst_bus_sequencer.sv
// tb_ldst_bus_sequencer: directed stimulus with a queue-based writeback/exception scoreboard
module tb_ldst_bus_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        exe_valid = 1'b0, exe_rw = 1'b0, flush = 1'b0;
   logic [31:0] exe_addr = 32'd0, exe_data = 32'd0;
   logic [1:0]  exe_order = 2'd0, exe_shift = 2'd0;
   logic        bus_busy = 1'b0, bus_valid = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        exe_busy, req, dio_rw, wb_valid, wb_rw, exc;
   logic [31:0] dio_addr, dio_data, wb_data, exc_addr;
   logic [1:0]  dio_order;
   logic [3:0]  dio_mask;
   int checks = 0, errors = 0;
   logic [32:0] wb_q[$];
   logic [31:0] exc_q[$];

   ldst_bus_sequencer dut (
      .iCLOCK(clk), .inRESET(rst_n), .iEXE_VALID(exe_valid), .oEXE_BUSY(exe_busy),
      .iEXE_RW(exe_rw), .iEXE_ADDR(exe_addr), .iEXE_DATA(exe_data), .iEXE_ORDER(exe_order),
      .iEXE_LOAD_SHIFT(exe_shift), .iFLUSH(flush), .oDATAIO_REQ(req), .iDATAIO_BUSY(bus_busy),
      .oDATAIO_RW(dio_rw), .oDATAIO_ADDR(dio_addr), .oDATAIO_DATA(dio_data),
      .oDATAIO_ORDER(dio_order), .oDATAIO_MASK(dio_mask), .iDATAIO_VALID(bus_valid),
      .iDATAIO_DATA(bus_rdata), .oWB_VALID(wb_valid), .oWB_RW(wb_rw), .oWB_DATA(wb_data),
      .oEXCEPT_ALIGN(exc), .oEXCEPT_ADDR(exc_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] order, input logic [1:0] shift);
      exe_valid = 1'b1; exe_rw = rw; exe_addr = addr; exe_data = data;
      exe_order = order; exe_shift = shift;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"}, {32'd0, req}, 33'd0);
      chk({tag, "_busy"}, {32'd0, exe_busy}, 33'd0);
      chk({tag, "_dio"}, {dio_rw, dio_addr}, 33'd0);
      chk({tag, "_dio_data"}, {1'b0, dio_data}, 33'd0);
      chk({tag, "_order_mask"}, {27'd0, dio_order, dio_mask}, 33'd0);
      chk({tag, "_wb"}, {wb_valid, wb_data}, 33'd0);
      chk({tag, "_wb_rw_exc"}, {30'd0, wb_rw, exc, 1'b0}, 33'd0);
      chk({tag, "_exc_addr"}, {1'b0, exc_addr}, 33'd0);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [1:0] order, input logic [1:0] shift,
                          input logic [31:0] resp, input logic [3:0] mask, input logic [31:0] exp);
      drive(1'b0, addr, 32'd0, order, shift);
      wb_q.push_back({1'b0, exp});
      tick();
      exe_valid = 1'b0;
      chk("load_req", {32'd0, req}, 33'd1);
      chk("load_mask", {29'd0, mask}, {29'd0, dio_mask});
      chk("load_addr", {1'b0, dio_addr}, {1'b0, addr});
      tick();
      chk("load_req_drop", {32'd0, req}, 33'd0);
      bus_valid = 1'b1; bus_rdata = resp;
      tick();
      bus_valid = 1'b0;
      chk("load_wb_timing", {32'd0, wb_valid}, 33'd1);
      tick();
   endtask

   always @(negedge clk) if (rst_n) begin
      if (wb_valid && exc) chk("wb_exc_overlap", 33'd1, 33'd0);
      if (wb_valid) begin
         if (wb_q.size() == 0) chk("unexpected_wb", {wb_rw, wb_data}, 33'h1_FFFF_FFFF);
         else chk("wb_scoreboard", {wb_rw, wb_data}, wb_q.pop_front());
      end
      if (exc) begin
         if (exc_q.size() == 0) chk("unexpected_exc", {1'b0, exc_addr}, 33'h1_FFFF_FFFF);
         else chk("exc_scoreboard", {1'b0, exc_addr}, {1'b0, exc_q.pop_front()});
      end
   end

   initial begin
      tick(); tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      // store word, bus busy for two cycles
      drive(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 2'd0);
      bus_busy = 1'b1;
      wb_q.push_back({1'b1, 32'd0});
      tick();
      exe_valid = 1'b0;
      chk("st_req1", {32'd0, req}, 33'd1);
      chk("st_mask", {29'd0, dio_mask}, 33'hF);
      chk("st_fields", {dio_rw, dio_data}, {1'b1, 32'hDEADBEEF});
      chk("st_busy", {32'd0, exe_busy}, 33'd1);
      tick();
      chk("st_req2", {32'd0, req}, 33'd1);
      tick();
      chk("st_req3", {32'd0, req}, 33'd1);
      bus_busy = 1'b0;
      tick();
      chk("st_wb", {30'd0, req, wb_valid, wb_rw}, 33'b011);
      chk("st_idle", {32'd0, exe_busy}, 33'd0);
      tick();
      do_load(32'h103, 2'd0, 2'd0, 32'h11223344, 4'b1000, 32'h44);
      do_load(32'h200, 2'd1, 2'd2, 32'hAABBCCDD, 4'b0011, 32'hAABB);
      // back-to-back misaligned and illegal requests
      drive(1'b0, 32'h102, 32'd0, 2'd2, 2'd0);
      exc_q.push_back(32'h102);
      tick();
      chk("mis_exc", {31'd0, exc, req}, 33'b10);
      chk("mis_busy", {32'd0, exe_busy}, 33'd0);
      drive(1'b1, 32'h300, 32'd5, 2'd3, 2'd0);
      exc_q.push_back(32'h300);
      tick();
      exe_valid = 1'b0;
      chk("ill_exc", {31'd0, exc, req}, 33'b10);
      tick();
      chk("mis_no_req", {31'd0, exc, req}, 33'd0);
      // flush in WAIT then drain
      drive(1'b0, 32'h400, 32'd0, 2'd2, 2'd0);
      tick();
      exe_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("drain_busy", {32'd0, exe_busy}, 33'd1);
      tick(); tick();
      bus_valid = 1'b1; bus_rdata = 32'h12345678;
      tick();
      bus_valid = 1'b0;
      chk("drain_done", {31'd0, exe_busy, wb_valid}, 33'd0);
      drive(1'b1, 32'h500, 32'h0, 2'd2, 2'd0);
      wb_q.push_back({1'b1, 32'd0});
      tick();
      exe_valid = 1'b0;
      chk("post_drain_req", {32'd0, req}, 33'd1);
      tick(); tick();
      // flush in REQ beats a same-cycle bus accept
      drive(1'b0, 32'h600, 32'd0, 2'd2, 2'd0);
      tick();
      exe_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_req", {31'd0, req, exe_busy}, 33'd0);
      bus_valid = 1'b1;
      tick();
      bus_valid = 1'b0;
      tick();
      // reset mid-REQ
      drive(1'b1, 32'h700, 32'hCAFEF00D, 2'd2, 2'd0);
      bus_busy = 1'b1;
      tick();
      exe_valid = 1'b0;
      chk("rst_pre_req", {32'd0, req}, 33'd1);
      rst_n = 1'b0;
      tick();
      check_all_zero("midreset");
      rst_n = 1'b1;
      bus_busy = 1'b0;
      bus_valid = 1'b1;
      tick();
      bus_valid = 1'b0;
      tick(); tick();
      chk("wb_q_empty", {1'b0, 32'(wb_q.size())}, 33'd0);
      chk("exc_q_empty", {1'b0, 32'(exc_q.size())}, 33'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
